// File: rtl/player_life_manager_if.sv
// Bundles the frame/game inputs and the life-status outputs of player_life_manager.
// The testbench or the game core drives through master; the life manager sits on slave.
interface player_life_manager_if #(
    parameter int LIVES_W = 3
);
    logic               frame_clk;
    logic [1:0]         gameState;
    logic               hit;
    logic               fell;
    logic               playerDead;
    logic [LIVES_W-1:0] lives;
    logic               dying;
    logic               invincible;
    logic               blink;
    logic               respawn;

    modport master (
        output frame_clk, gameState, hit, fell,
        input  playerDead, lives, dying, invincible, blink, respawn
    );

    modport slave (
        input  frame_clk, gameState, hit, fell,
        output playerDead, lives, dying, invincible, blink, respawn
    );
endinterface

// File: rtl/player_life_manager.sv
// Player life tracking: lives count, frame-timed death animation and post-spawn
// invincibility, with the playerDead level handed to the game-state controller.
module player_life_manager #(
    parameter int START_LIVES   = 3,
    parameter int LIVES_W       = 3,
    parameter int DEATH_FRAMES  = 60,
    parameter int INVULN_FRAMES = 120,
    parameter int CNT_W         = 8
) (
    input  logic Clk,
    input  logic Reset,
    player_life_manager_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INVULN = 3'd1,
        S_ALIVE  = 3'd2,
        S_DYING  = 3'd3,
        S_DEAD   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               frame_prev_q;
    logic               respawn_q, respawn_d;

    logic frame_tick;
    logic in_play;
    logic cnt_last;
    logic death_ev;

    // vsync is a level; a frame starts on its rising edge as seen in Clk.
    assign frame_tick = bus.frame_clk & ~frame_prev_q;
    assign in_play    = (bus.gameState == 2'b01);
    assign cnt_last   = (cnt_q == CNT_W'(1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            lives_q      <= LIVES_W'(START_LIVES);
            cnt_q        <= '0;
            frame_prev_q <= 1'b0;
            respawn_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            cnt_q        <= cnt_d;
            frame_prev_q <= bus.frame_clk;
            respawn_q    <= respawn_d;
        end
    end

    // Leaving Play outranks every other transition, including a pending death.
    always_comb begin
        state_d  = state_q;
        death_ev = 1'b0;
        if (state_q != S_IDLE && !in_play) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_play) state_d = S_INVULN;
                end
                S_INVULN: begin
                    if (bus.fell) begin
                        state_d  = S_DYING;
                        death_ev = 1'b1;
                    end else if (frame_tick && cnt_last) begin
                        state_d = S_ALIVE;
                    end
                end
                S_ALIVE: begin
                    if (bus.hit || bus.fell) begin
                        state_d  = S_DYING;
                        death_ev = 1'b1;
                    end
                end
                S_DYING: begin
                    if (frame_tick && cnt_last)
                        state_d = (lives_q == '0) ? S_DEAD : S_INVULN;
                end
                S_DEAD: begin
                    state_d = S_DEAD;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Lives and the shared frame counter follow the chosen transition.
    always_comb begin
        lives_d   = lives_q;
        cnt_d     = cnt_q;
        respawn_d = (state_d == S_INVULN) && (state_q != S_INVULN);

        // Reloading on the way into IDLE makes the fresh count visible immediately.
        if (state_q == S_IDLE || state_d == S_IDLE)
            lives_d = LIVES_W'(START_LIVES);
        else if (death_ev)
            lives_d = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);

        if (state_d == S_IDLE)
            cnt_d = '0;
        else if (death_ev)
            cnt_d = CNT_W'(DEATH_FRAMES);
        else if (respawn_d)
            cnt_d = CNT_W'(INVULN_FRAMES);
        else if (frame_tick && (state_q == S_INVULN || state_q == S_DYING))
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_comb begin
        bus.playerDead = (state_q == S_DEAD);
        bus.dying      = (state_q == S_DYING);
        bus.invincible = (state_q == S_INVULN);
        bus.blink      = (state_q == S_INVULN) && cnt_q[2];
        bus.lives      = lives_q;
        bus.respawn    = respawn_q;
    end

endmodule

// File: tb/tb_player_life_manager.sv
// Directed walk through the life/death scenarios, then random play, every cycle
// compared against a frame-level behavioural model of the player's life.
module tb_player_life_manager;

    localparam int START_LIVES   = 3;
    localparam int LIVES_W       = 3;
    localparam int DEATH_FRAMES  = 60;
    localparam int INVULN_FRAMES = 120;
    localparam int CNT_W         = 8;

    // Model phases of the player's life
    localparam int P_OFF    = 0;
    localparam int P_SHIELD = 1;
    localparam int P_PLAY   = 2;
    localparam int P_DOWN   = 3;
    localparam int P_OUT    = 4;

    logic Clk;
    logic Reset;

    player_life_manager_if #(.LIVES_W(LIVES_W)) bus ();

    player_life_manager #(
        .START_LIVES  (START_LIVES),
        .LIVES_W      (LIVES_W),
        .DEATH_FRAMES (DEATH_FRAMES),
        .INVULN_FRAMES(INVULN_FRAMES),
        .CNT_W        (CNT_W)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks_cnt   = 0;
    int failures_cnt = 0;

    int m_phase   = P_OFF;
    int m_lives   = START_LIVES;
    int m_frames  = 0;
    int m_prev_vs = 0;
    int m_respawn = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        checks_cnt++;
        if (got != exp) begin
            failures_cnt++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_lose_life();
        m_lives  = (m_lives > 0) ? m_lives - 1 : 0;
        m_frames = DEATH_FRAMES;
        m_phase  = P_DOWN;
    endtask

    // One Clk of the player's life, stated in terms of frames and lives.
    task automatic model_step(input int rst, input int fc, input int gs, input int h, input int f);
        int tick;
        int new_respawn;
        if (rst != 0) begin
            m_phase = P_OFF; m_lives = START_LIVES; m_frames = 0;
            m_prev_vs = 0; m_respawn = 0;
            return;
        end
        tick        = (fc != 0 && m_prev_vs == 0) ? 1 : 0;
        m_prev_vs   = fc;
        new_respawn = 0;
        if (m_phase != P_OFF && gs != 1) begin
            m_phase = P_OFF; m_lives = START_LIVES; m_frames = 0;
        end else begin
            case (m_phase)
                P_OFF: begin
                    m_lives = START_LIVES;
                    if (gs == 1) begin
                        m_phase = P_SHIELD; m_frames = INVULN_FRAMES; new_respawn = 1;
                    end
                end
                P_SHIELD: begin
                    if (f != 0) model_lose_life();
                    else if (tick != 0) begin
                        if (m_frames == 1) m_phase = P_PLAY;
                        m_frames = m_frames - 1;
                    end
                end
                P_PLAY: begin
                    if (h != 0 || f != 0) model_lose_life();
                end
                P_DOWN: begin
                    if (tick != 0) begin
                        if (m_frames == 1) begin
                            if (m_lives == 0) m_phase = P_OUT;
                            else begin
                                m_phase = P_SHIELD; m_frames = INVULN_FRAMES; new_respawn = 1;
                            end
                        end else begin
                            m_frames = m_frames - 1;
                        end
                    end
                end
                default: ;
            endcase
        end
        m_respawn = new_respawn;
    endtask

    task automatic compare_all();
        check_val("playerDead", int'(bus.playerDead), (m_phase == P_OUT) ? 1 : 0);
        check_val("dying",      int'(bus.dying),      (m_phase == P_DOWN) ? 1 : 0);
        check_val("invincible", int'(bus.invincible), (m_phase == P_SHIELD) ? 1 : 0);
        check_val("blink",      int'(bus.blink),
                  (m_phase == P_SHIELD) ? ((m_frames / 4) % 2) : 0);
        check_val("lives",      int'(bus.lives),      m_lives);
        check_val("respawn",    int'(bus.respawn),    m_respawn);
    endtask

    task automatic step(input int rst, input int fc, input int gs, input int h, input int f);
        Reset         = (rst != 0);
        bus.frame_clk = (fc != 0);
        bus.gameState = 2'(gs);
        bus.hit       = (h != 0);
        bus.fell      = (f != 0);
        @(posedge Clk);
        model_step(rst, fc, gs, h, f);
        #1;
        compare_all();
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 1, 1, 0, 0);
            step(0, 0, 1, 0, 0);
        end
    endtask

    initial begin
        int fc_lvl;
        int gs_lvl;

        Reset = 1'b1; bus.frame_clk = 1'b0; bus.gameState = 2'b00;
        bus.hit = 1'b0; bus.fell = 1'b0;
        #1;

        repeat (3) step(1, 0, 0, 0, 0);
        check_val("rst_playerDead", int'(bus.playerDead), 0);
        check_val("rst_lives",      int'(bus.lives), 3);
        check_val("rst_invincible", int'(bus.invincible), 0);
        check_val("rst_respawn",    int'(bus.respawn), 0);
        $display("scenario reset: lives=%0d", bus.lives);
        step(0, 0, 0, 0, 0);

        step(0, 0, 1, 0, 0);
        check_val("start_invincible", int'(bus.invincible), 1);
        check_val("start_respawn",    int'(bus.respawn), 1);
        step(0, 0, 1, 0, 0);
        check_val("start_respawn_drop", int'(bus.respawn), 0);
        repeat (10) step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        tick_n(INVULN_FRAMES - 2);
        check_val("held_vsync_one_tick", int'(bus.invincible), 1);
        tick_n(1);
        check_val("invuln_expired", int'(bus.invincible), 0);
        $display("scenario spawn: invincible window over, lives=%0d", bus.lives);

        step(0, 0, 1, 1, 0);
        check_val("hit_dying", int'(bus.dying), 1);
        check_val("hit_lives", int'(bus.lives), 2);
        tick_n(DEATH_FRAMES);
        check_val("respawn_invincible", int'(bus.invincible), 1);
        step(0, 0, 1, 1, 0);
        check_val("invuln_hit_ignored", int'(bus.dying), 0);
        check_val("invuln_hit_lives",   int'(bus.lives), 2);
        step(0, 0, 1, 0, 1);
        check_val("invuln_fell_dying", int'(bus.dying), 1);
        check_val("invuln_fell_lives", int'(bus.lives), 1);
        $display("scenario deaths: lives=%0d", bus.lives);

        tick_n(DEATH_FRAMES);
        tick_n(INVULN_FRAMES);
        check_val("alive_again", int'(bus.invincible), 0);
        step(0, 0, 1, 1, 1);
        check_val("double_event_lives", int'(bus.lives), 0);
        tick_n(DEATH_FRAMES);
        check_val("game_over_dead",    int'(bus.playerDead), 1);
        check_val("game_over_respawn", int'(bus.respawn), 0);
        step(0, 0, 2, 0, 0);
        check_val("leave_play_dead", int'(bus.playerDead), 0);
        $display("scenario game over: playerDead cleared");

        step(0, 0, 1, 0, 0);
        check_val("restart_lives",   int'(bus.lives), 3);
        check_val("restart_respawn", int'(bus.respawn), 1);
        tick_n(INVULN_FRAMES);
        step(0, 0, 1, 1, 0);
        check_val("restart_first_death", int'(bus.lives), 2);
        tick_n(30);
        step(0, 0, 0, 0, 0);
        check_val("abort_dying", int'(bus.dying), 0);
        check_val("abort_lives", int'(bus.lives), 3);
        $display("scenario restart/abort: lives=%0d", bus.lives);

        step(0, 0, 1, 0, 0);
        tick_n(10);
        step(1, 1, 1, 1, 1);
        check_val("rst_mid_invuln_inv",     int'(bus.invincible), 0);
        check_val("rst_mid_invuln_lives",   int'(bus.lives), 3);
        check_val("rst_mid_invuln_respawn", int'(bus.respawn), 0);
        step(0, 0, 1, 0, 0);
        tick_n(INVULN_FRAMES);
        step(0, 1, 1, 1, 0);
        check_val("tick_hit_dying", int'(bus.dying), 1);
        repeat (9) step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        tick_n(DEATH_FRAMES - 1);
        check_val("death_len_not_short", int'(bus.dying), 1);
        tick_n(1);
        check_val("death_len_exact", int'(bus.invincible), 1);
        $display("scenario tick+hit: death lasted %0d frames", DEATH_FRAMES);

        fc_lvl = 0;
        gs_lvl = 1;
        for (int c = 0; c < 20000; c++) begin
            int rst_r;
            int h_r;
            int f_r;
            if ($urandom_range(1) == 0) fc_lvl = 1 - fc_lvl;
            if ($urandom_range(499) == 0) gs_lvl = int'($urandom_range(2));
            else if (gs_lvl != 1 && $urandom_range(19) == 0) gs_lvl = 1;
            rst_r = ($urandom_range(1999) == 0) ? 1 : 0;
            h_r   = ($urandom_range(299) == 0) ? 1 : 0;
            f_r   = ($urandom_range(599) == 0) ? 1 : 0;
            step(rst_r, fc_lvl, gs_lvl, h_r, f_r);
        end
        $display("scenario random: 20000 cycles");

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
